// File: rtl/imem_loader.sv
// imem_loader: boot-time instruction memory loader.
// Parses a framed serial byte stream (SYNC, LEN_LO, LEN_HI, data..., CHK),
// writes the data bytes into the instruction memory from address 0, and keeps
// the CPU in reset until a complete image with a matching checksum is stored.
module imem_loader #(
  parameter int          ADDR_WIDTH = 12,
  parameter int          MEM_WIDTH  = 8,
  parameter logic [7:0]  SYNC_BYTE  = 8'hA5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic                  rx_ready,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [MEM_WIDTH-1:0]  din,
  output logic                  cpu_hold,
  output logic                  load_done,
  output logic                  load_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_t;

  // Largest legal image length: exactly fills the memory.
  localparam logic [16:0] CAPACITY = 17'd1 << ADDR_WIDTH;

  state_t                state;
  logic [7:0]            len_lo;
  logic [15:0]           len;
  logic [15:0]           count;
  logic [ADDR_WIDTH-1:0] addr;
  logic [7:0]            sum;

  logic                  accept;
  logic [16:0]           len_next;

  assign accept   = rx_valid && rx_ready;
  // Full length as it becomes known while the high byte is on rx_data.
  assign len_next = {1'b0, rx_data, len_lo};

  // Ready depends on the state only; every state drains bytes so the source never stalls.
  always_comb begin
    // NOTE: every output of a combinational block gets a value on every path, otherwise a latch is inferred.
    rx_ready = 1'b1;
    case (state)
      S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA,
      S_CHECK, S_DONE, S_ERROR: rx_ready = 1'b1;
      default:                  rx_ready = 1'b1;
    endcase
  end

  // Frame parser, address/checksum tracking and registered memory-write / status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      len_lo    <= '0;
      len       <= '0;
      count     <= '0;
      addr      <= '0;
      sum       <= '0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      din       <= '0;
      cpu_hold  <= 1'b1;
      load_done <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      // Write strobe is a single-cycle pulse; only an accepted data byte re-arms it.
      wr_en <= 1'b0;
      if (accept) begin
        case (state)
          S_IDLE: begin
            if (rx_data == SYNC_BYTE) state <= S_LEN_LO;
          end
          S_LEN_LO: begin
            len_lo <= rx_data;
            state  <= S_LEN_HI;
          end
          S_LEN_HI: begin
            len   <= len_next[15:0];
            count <= '0;
            addr  <= '0;
            // Cleared for zero-length frames too, whose checksum must be 0.
            sum   <= '0;
            if (len_next == 17'd0) begin
              state <= S_CHECK;
            end else if (len_next > CAPACITY) begin
              state    <= S_ERROR;
              load_err <= 1'b1;
              cpu_hold <= 1'b1;
            end else begin
              state <= S_DATA;
            end
          end
          S_DATA: begin
            wr_en   <= 1'b1;
            wr_addr <= addr;
            din     <= rx_data;
            // Wraps to 0 after a full-capacity image; no write follows it.
            addr    <= addr + ADDR_WIDTH'(1);
            sum     <= sum + rx_data;
            count   <= count + 16'd1;
            if (count == len - 16'd1) state <= S_CHECK;
          end
          S_CHECK: begin
            if (rx_data == sum) begin
              state     <= S_DONE;
              cpu_hold  <= 1'b0;
              load_done <= 1'b1;
            end else begin
              state    <= S_ERROR;
              load_err <= 1'b1;
              cpu_hold <= 1'b1;
            end
          end
          S_DONE: begin
            // A new sync byte starts a reload and puts the CPU back into reset.
            if (rx_data == SYNC_BYTE) begin
              state     <= S_LEN_LO;
              cpu_hold  <= 1'b1;
              load_done <= 1'b0;
            end
          end
          S_ERROR: begin
            // Sticky until reset; bytes are simply drained.
            state <= S_ERROR;
          end
          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: a cycle-by-cycle vector table for the
// nominal, error and reload scenarios, hand-written full-load and mid-frame
// reset sequences, and randomized frames checked against a frame-level model.
module tb_imem_loader;

  localparam int         AW   = 12;
  localparam int         CAP  = 1 << AW;
  localparam logic [7:0] SYNC = 8'hA5;

  logic          clk = 1'b0;
  logic          rst;
  logic          rx_valid;
  logic [7:0]    rx_data;
  logic          rx_ready;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    din;
  logic          cpu_hold;
  logic          load_done;
  logic          load_err;

  imem_loader #(.ADDR_WIDTH(AW), .MEM_WIDTH(8), .SYNC_BYTE(SYNC)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .rx_ready  (rx_ready),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .din       (din),
    .cpu_hold  (cpu_hold),
    .load_done (load_done),
    .load_err  (load_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Every write the DUT issues, as {addr, data}.
  logic [19:0] got_q[$];
  always @(negedge clk) begin
    if (wr_en === 1'b1) got_q.push_back({wr_addr, din});
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic          rst;
    logic          valid;
    logic [7:0]    data;
    logic          exp_wr;
    logic          chk_bus;
    logic [AW-1:0] exp_addr;
    logic [7:0]    exp_din;
    logic          exp_hold;
    logic          exp_done;
    logic          exp_err;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic r, logic v, logic [7:0] d, logic w,
                              logic [AW-1:0] a, logic [7:0] dd,
                              logic h, logic dn, logic e);
    vec_t x;
    x.rst = r; x.valid = v; x.data = d; x.exp_wr = w;
    x.chk_bus = w | r; x.exp_addr = a; x.exp_din = dd;
    x.exp_hold = h; x.exp_done = dn; x.exp_err = e;
    return x;
  endfunction

  // ---------------- byte-level helpers ----------------
  task automatic do_reset();
    rst = 1'b1;
    rx_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Send one byte; the write (if any) must appear right after the accepting edge.
  task automatic send_byte(input logic [7:0] b, input bit is_data, input logic [AW-1:0] a);
    rx_valid = 1'b1;
    rx_data  = b;
    #1;
    check("rx_ready", rx_ready, 1'b1);
    @(posedge clk); #1;
    rx_valid = 1'b0;
    check("wr_timing", wr_en, is_data);
    if (is_data) begin
      check("wr_addr", wr_addr, a);
      check("din", din, b);
    end
  endtask

  task automatic stall(input int n);
    rx_valid = 1'b0;
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      check("stall_no_write", wr_en, 1'b0);
    end
  endtask

  // Frame-level reference: data goes to addr 0..len-1, outcome is decided by
  // the length bound and the mod-256 sum of the data.
  task automatic run_frame(input int len, input bit bad_chk, input bit gaps, input int garbage);
    logic [7:0] data[$];
    logic [7:0] sum;
    logic [7:0] b;
    int         n_bad;
    bit         over;
    got_q.delete();
    for (int g = 0; g < garbage; g++) begin
      b = 8'($urandom_range(0, 255));
      if (b == SYNC) b = 8'h00;
      send_byte(b, 1'b0, '0);
    end
    over = (len > CAP);
    sum  = 8'h00;
    for (int i = 0; i < (over ? 0 : len); i++) begin
      b = 8'($urandom_range(0, 255));
      data.push_back(b);
      sum = sum + b;
    end
    send_byte(SYNC, 1'b0, '0);
    check("hold_after_sync", cpu_hold, 1'b1);
    check("done_after_sync", load_done, 1'b0);
    send_byte(8'(len & 255), 1'b0, '0);
    send_byte(8'((len >> 8) & 255), 1'b0, '0);
    if (over) begin
      for (int k = 0; k < 3; k++) send_byte(8'($urandom_range(0, 255)), 1'b0, '0);
    end else begin
      for (int i = 0; i < len; i++) begin
        if (gaps && ($urandom_range(0, 2) == 0)) stall($urandom_range(1, 3));
        send_byte(data[i], 1'b1, AW'(i));
      end
      send_byte(bad_chk ? sum + 8'h01 : sum, 1'b0, '0);
    end
    check("n_writes", got_q.size(), over ? 0 : len);
    n_bad = 0;
    for (int i = 0; i < got_q.size() && i < data.size(); i++)
      if (got_q[i] !== {AW'(i), data[i]}) n_bad++;
    check("write_contents", n_bad, 0);
    if (over || bad_chk) begin
      check("end_err", load_err, 1'b1);
      check("end_hold", cpu_hold, 1'b1);
      check("end_done", load_done, 1'b0);
    end else begin
      check("end_err", load_err, 1'b0);
      check("end_hold", cpu_hold, 1'b0);
      check("end_done", load_done, 1'b1);
    end
  endtask

  initial begin
    bit prev_bad;
    int len;
    int r;

    rst = 1'b1;
    rx_valid = 1'b0;
    rx_data = 8'h00;

    // ---- table: reset, garbage, nominal load with a stall, ignore in DONE ----
    tbl.push_back(mk(1, 0, 8'h00, 0, 12'h000, 8'h00, 1, 0, 0));
    tbl.push_back(mk(0, 1, 8'h00, 0, 12'h000, 8'h00, 1, 0, 0));
    tbl.push_back(mk(0, 1, 8'hFF, 0, 12'h000, 8'h00, 1, 0, 0));
    tbl.push_back(mk(0, 1, 8'h12, 0, 12'h000, 8'h00, 1, 0, 0));
    tbl.push_back(mk(0, 1, 8'hA5, 0, 12'h000, 8'h00, 1, 0, 0));
    tbl.push_back(mk(0, 1, 8'h04, 0, 12'h000, 8'h00, 1, 0, 0));
    tbl.push_back(mk(0, 1, 8'h00, 0, 12'h000, 8'h00, 1, 0, 0));
    tbl.push_back(mk(0, 1, 8'h13, 1, 12'h000, 8'h13, 1, 0, 0));
    tbl.push_back(mk(0, 0, 8'h55, 0, 12'h000, 8'h00, 1, 0, 0));
    tbl.push_back(mk(0, 1, 8'h00, 1, 12'h001, 8'h00, 1, 0, 0));
    tbl.push_back(mk(0, 1, 8'h00, 1, 12'h002, 8'h00, 1, 0, 0));
    tbl.push_back(mk(0, 1, 8'h00, 1, 12'h003, 8'h00, 1, 0, 0));
    tbl.push_back(mk(0, 1, 8'h13, 0, 12'h000, 8'h00, 0, 1, 0));
    tbl.push_back(mk(0, 1, 8'h42, 0, 12'h000, 8'h00, 0, 1, 0));
    tbl.push_back(mk(1, 0, 8'h00, 0, 12'h000, 8'h00, 1, 0, 0));
    // ---- bad checksum, sticky error ----
    tbl.push_back(mk(0, 1, 8'hA5, 0, 12'h000, 8'h00, 1, 0, 0));
    tbl.push_back(mk(0, 1, 8'h04, 0, 12'h000, 8'h00, 1, 0, 0));
    tbl.push_back(mk(0, 1, 8'h00, 0, 12'h000, 8'h00, 1, 0, 0));
    tbl.push_back(mk(0, 1, 8'h13, 1, 12'h000, 8'h13, 1, 0, 0));
    tbl.push_back(mk(0, 1, 8'h00, 1, 12'h001, 8'h00, 1, 0, 0));
    tbl.push_back(mk(0, 1, 8'h00, 1, 12'h002, 8'h00, 1, 0, 0));
    tbl.push_back(mk(0, 1, 8'h00, 1, 12'h003, 8'h00, 1, 0, 0));
    tbl.push_back(mk(0, 1, 8'h14, 0, 12'h000, 8'h00, 1, 0, 1));
    tbl.push_back(mk(0, 1, 8'hA5, 0, 12'h000, 8'h00, 1, 0, 1));
    tbl.push_back(mk(0, 1, 8'h04, 0, 12'h000, 8'h00, 1, 0, 1));
    tbl.push_back(mk(1, 0, 8'h00, 0, 12'h000, 8'h00, 1, 0, 0));
    // ---- length 4097: immediate error, no writes ----
    tbl.push_back(mk(0, 1, 8'hA5, 0, 12'h000, 8'h00, 1, 0, 0));
    tbl.push_back(mk(0, 1, 8'h01, 0, 12'h000, 8'h00, 1, 0, 0));
    tbl.push_back(mk(0, 1, 8'h10, 0, 12'h000, 8'h00, 1, 0, 1));
    tbl.push_back(mk(0, 1, 8'h13, 0, 12'h000, 8'h00, 1, 0, 1));
    tbl.push_back(mk(1, 0, 8'h00, 0, 12'h000, 8'h00, 1, 0, 0));
    // ---- zero length, then reload from DONE ----
    tbl.push_back(mk(0, 1, 8'hA5, 0, 12'h000, 8'h00, 1, 0, 0));
    tbl.push_back(mk(0, 1, 8'h00, 0, 12'h000, 8'h00, 1, 0, 0));
    tbl.push_back(mk(0, 1, 8'h00, 0, 12'h000, 8'h00, 1, 0, 0));
    tbl.push_back(mk(0, 1, 8'h00, 0, 12'h000, 8'h00, 0, 1, 0));
    tbl.push_back(mk(0, 1, 8'hA5, 0, 12'h000, 8'h00, 1, 0, 0));
    tbl.push_back(mk(0, 1, 8'h01, 0, 12'h000, 8'h00, 1, 0, 0));
    tbl.push_back(mk(0, 1, 8'h00, 0, 12'h000, 8'h00, 1, 0, 0));
    tbl.push_back(mk(0, 1, 8'h6F, 1, 12'h000, 8'h6F, 1, 0, 0));
    tbl.push_back(mk(0, 1, 8'h6F, 0, 12'h000, 8'h00, 0, 1, 0));
    tbl.push_back(mk(1, 0, 8'h00, 0, 12'h000, 8'h00, 1, 0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      rst      = tbl[i].rst;
      rx_valid = tbl[i].valid;
      rx_data  = tbl[i].data;
      #1;
      check($sformatf("v%0d_rx_ready", i), rx_ready, 1'b1);
      @(posedge clk); #1;
      check($sformatf("v%0d_wr_en", i), wr_en, tbl[i].exp_wr);
      if (tbl[i].chk_bus) begin
        check($sformatf("v%0d_wr_addr", i), wr_addr, tbl[i].exp_addr);
        check($sformatf("v%0d_din", i), din, tbl[i].exp_din);
      end
      check($sformatf("v%0d_cpu_hold", i), cpu_hold, tbl[i].exp_hold);
      check($sformatf("v%0d_load_done", i), load_done, tbl[i].exp_done);
      check($sformatf("v%0d_load_err", i), load_err, tbl[i].exp_err);
    end
    rst = 1'b0;
    rx_valid = 1'b0;

    // ---- full-capacity load: last write at 0xFFF, then DONE ----
    run_frame(CAP, 1'b0, 1'b0, 0);
    check("full_last_addr", (got_q.size() > 0) ? 32'(got_q[got_q.size()-1][19:8]) : 32'hFFFF_FFFF, 32'hFFF);

    // ---- reset mid-frame after 2 of 4 data bytes ----
    do_reset();
    send_byte(SYNC, 1'b0, '0);
    send_byte(8'h04, 1'b0, '0);
    send_byte(8'h00, 1'b0, '0);
    send_byte(8'h11, 1'b1, 12'h000);
    send_byte(8'h22, 1'b1, 12'h001);
    do_reset();
    check("midrst_wr_en", wr_en, 1'b0);
    check("midrst_hold", cpu_hold, 1'b1);
    check("midrst_done", load_done, 1'b0);
    run_frame(4, 1'b0, 1'b1, 0);

    // ---- randomized frames against the frame-level model ----
    prev_bad = 1'b0;
    for (int f = 0; f < 40; f++) begin
      if (prev_bad || ($urandom_range(0, 2) == 0)) do_reset();
      r = $urandom_range(0, 99);
      if (r < 70)      len = $urandom_range(0, 24);
      else if (r < 85) len = $urandom_range(25, 300);
      else             len = $urandom_range(CAP + 1, 65535);
      prev_bad = (len > CAP) || ($urandom_range(0, 3) == 0);
      run_frame(len, prev_bad && (len <= CAP), 1'b1, $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
